// File: rtl/mem_access_pkg.sv
// mem_access_pkg
//   Shared types and constants for the memory stage: load/store opcodes,
//   the funct3 access-size encoding and the mem_access state type.
//   Also used by writeback (OP_LOAD) and by dcache models in benches.
//   No ports.
package mem_access_pkg;

  typedef logic [6:0] opcode_t;

  localparam opcode_t OP_LOAD  = 7'b0000011;
  localparam opcode_t OP_STORE = 7'b0100011;

  typedef enum logic [2:0] {
    MEM_B  = 3'b000,
    MEM_H  = 3'b001,
    MEM_W  = 3'b010,
    MEM_BU = 3'b100,
    MEM_HU = 3'b101
  } mem_funct3_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } mem_state_t;

  // Stores only have signed-size encodings; loads also accept BU/HU.
  function automatic logic f3_valid(input logic is_store, input logic [2:0] f3);
    logic ok;
    ok = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
    if (!is_store) begin
      ok = ok || (f3 == 3'b100) || (f3 == 3'b101);
    end
    return ok;
  endfunction

endpackage

// File: rtl/mem_align.sv
// mem_align
//   Combinational lane logic for 32-bit little-endian accesses.
//   Produces byte enables and lane-replicated store data from funct3/offset,
//   and extracts/extends the addressed byte or halfword of a read word.
//   Misaligned halfword/word offsets are truncated (off[0] / off[1:0] ignored).
// Ports:
//   funct3_i     access size/sign
//   off_i        byte offset within the word
//   rs2_data_i   store data
//   rdata_i      read word from the dcache
//   be_o         byte enables
//   wdata_o      replicated store data
//   load_data_o  aligned, extended load result
module mem_align
  import mem_access_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [2:0]        funct3_i,
  input  logic [1:0]        off_i,
  input  logic [DATA_W-1:0] rs2_data_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic [3:0]        be_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic [DATA_W-1:0] load_data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata_i[{off_i, 3'b000} +: 8];
    half_sel = rdata_i[{off_i[1], 4'b0000} +: 16];
  end

  always_comb begin
    be_o    = 4'b1111;
    wdata_o = rs2_data_i;
    case (funct3_i[1:0])
      2'b00: begin
        be_o    = 4'b0001 << off_i;
        wdata_o = {4{rs2_data_i[7:0]}};
      end
      2'b01: begin
        be_o    = 4'b0011 << {off_i[1], 1'b0};
        wdata_o = {2{rs2_data_i[15:0]}};
      end
      default: begin
        be_o    = 4'b1111;
        wdata_o = rs2_data_i;
      end
    endcase
  end

  always_comb begin
    load_data_o = rdata_i;
    case (funct3_i)
      MEM_B:   load_data_o = {{24{byte_sel[7]}}, byte_sel};
      MEM_BU:  load_data_o = {24'd0, byte_sel};
      MEM_H:   load_data_o = {{16{half_sel[15]}}, half_sel};
      MEM_HU:  load_data_o = {16'd0, half_sel};
      default: load_data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// mem_access
//   Memory stage between decode_execute and writeback. Issues load/store
//   requests to the dcache over a req/ack handshake, aligns/extends load
//   data into dcache_out and pulses done for one cycle per instruction.
//   Non-memory instructions and invalid funct3 complete without an access.
//   Optional build macro MEM_MISALIGN_TRAP_EN adds the misalign output and
//   suppresses misaligned halfword/word accesses instead of truncating them.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   start/opcode/funct3       instruction from decode_execute
//   alu_out, rs2_data         effective address, store data
//   dc_req/dc_we/dc_addr/dc_wdata/dc_be   dcache request, held until dc_ack
//   dc_ack, dc_rdata          dcache completion and read word
//   dcache_out, done, busy    result, completion strobe, stall indication
//   misalign                  (MEM_MISALIGN_TRAP_EN only) misaligned access
module mem_access
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [6:0]        opcode,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] alu_out,
  input  logic [DATA_W-1:0] rs2_data,
  output logic              dc_req,
  output logic              dc_we,
  output logic [ADDR_W-1:0] dc_addr,
  output logic [DATA_W-1:0] dc_wdata,
  output logic [3:0]        dc_be,
  input  logic              dc_ack,
  input  logic [DATA_W-1:0] dc_rdata,
  output logic [DATA_W-1:0] dcache_out,
  output logic              done,
  output logic              busy
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic              misalign
`endif
);

  mem_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;
  logic [2:0]        f3_q, f3_d;
  logic [1:0]        off_q, off_d;
  logic [DATA_W-1:0] dout_q, dout_d;

  logic              is_load, is_store, mem_ok, trap;
  logic [2:0]        al_f3;
  logic [1:0]        al_off;
  logic [3:0]        al_be;
  logic [DATA_W-1:0] al_wdata, al_load;

  assign is_load  = (opcode == OP_LOAD);
  assign is_store = (opcode == OP_STORE);
  assign mem_ok   = (is_load || is_store) && f3_valid(is_store, funct3);

`ifdef MEM_MISALIGN_TRAP_EN
  logic mis_q, mis_d;
  assign trap = mem_ok &&
                (((funct3[1:0] == 2'b01) && alu_out[0]) ||
                 ((funct3[1:0] == 2'b10) && (alu_out[1:0] != 2'b00)));
  assign misalign = mis_q;
`else
  assign trap = 1'b0;
`endif

  // One aligner serves both directions: in IDLE it sees the incoming
  // instruction (store lanes/be), afterwards the latched access (load extract).
  assign al_f3  = (state_q == IDLE) ? funct3       : f3_q;
  assign al_off = (state_q == IDLE) ? alu_out[1:0] : off_q;

  mem_align #(.DATA_W(DATA_W)) u_align (
    .funct3_i    (al_f3),
    .off_i       (al_off),
    .rs2_data_i  (rs2_data),
    .rdata_i     (dc_rdata),
    .be_o        (al_be),
    .wdata_o     (al_wdata),
    .load_data_o (al_load)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    f3_d    = f3_q;
    off_d   = off_q;
    dout_d  = dout_q;
`ifdef MEM_MISALIGN_TRAP_EN
    mis_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          if (mem_ok && !trap) begin
            addr_d  = {alu_out[ADDR_W-1:2], 2'b00};
            we_d    = is_store;
            wdata_d = al_wdata;
            be_d    = al_be;
            f3_d    = funct3;
            off_d   = alu_out[1:0];
            state_d = ACCESS;
          end else begin
            dout_d  = '0;
            state_d = RESP;
`ifdef MEM_MISALIGN_TRAP_EN
            mis_d   = trap;
`endif
          end
        end
      end
      ACCESS: begin
        if (dc_ack) begin
          dout_d  = we_q ? '0 : al_load;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      be_q    <= '0;
      f3_q    <= '0;
      off_q   <= '0;
      dout_q  <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
      mis_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
      dout_q  <= dout_d;
`ifdef MEM_MISALIGN_TRAP_EN
      mis_q   <= mis_d;
`endif
    end
  end

  assign dc_req     = (state_q == ACCESS);
  assign dc_we      = dc_req && we_q;
  assign dc_addr    = addr_q;
  assign dc_wdata   = wdata_q;
  assign dc_be      = be_q;
  assign dcache_out = dout_q;
  assign done       = (state_q == RESP);
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_mem_access.sv
module tb_mem_access;

  localparam logic [6:0] LOAD_OP  = 7'b0000011;
  localparam logic [6:0] STORE_OP = 7'b0100011;
  localparam logic [6:0] OPIMM_OP = 7'b0010011;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [6:0]  opcode = '0;
  logic [2:0]  funct3 = '0;
  logic [31:0] alu_out = '0;
  logic [31:0] rs2_data = '0;
  logic        dc_req, dc_we, dc_ack = 1'b0;
  logic [31:0] dc_addr, dc_wdata, dc_rdata = '0, dcache_out;
  logic [3:0]  dc_be;
  logic        done, busy;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        misalign;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_access #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .opcode     (opcode),
    .funct3     (funct3),
    .alu_out    (alu_out),
    .rs2_data   (rs2_data),
    .dc_req     (dc_req),
    .dc_we      (dc_we),
    .dc_addr    (dc_addr),
    .dc_wdata   (dc_wdata),
    .dc_be      (dc_be),
    .dc_ack     (dc_ack),
    .dc_rdata   (dc_rdata),
    .dcache_out (dcache_out),
    .done       (done),
    .busy       (busy)
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    .misalign   (misalign)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---- reference model: byte arithmetic on a little-endian word ----
  function automatic int nbytes(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic int eff_off(input logic [2:0] f3, input logic [1:0] off);
    int n;
    n = nbytes(f3);
    return (int'(off) / n) * n;   // round down to the access size
  endfunction

  function automatic logic [31:0] size_mask(input logic [2:0] f3);
    return (nbytes(f3) == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes(f3))) - 32'd1);
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [1:0] off);
    logic [31:0] v;
    v = ((32'd1 << nbytes(f3)) - 32'd1) << eff_off(f3, off);
    return v[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] rs2);
    if (nbytes(f3) == 1) return {24'd0, rs2[7:0]} * 32'h0101_0101;
    if (nbytes(f3) == 2) return {16'd0, rs2[15:0]} * 32'h0001_0001;
    return rs2;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [1:0] off,
                                         input logic [31:0] rd);
    logic [31:0] v, msk;
    msk = size_mask(f3);
    v   = (rd >> (8 * eff_off(f3, off))) & msk;
    if (!f3[2] && ((v & ~(msk >> 1)) != 0)) v = v | ~msk;
    return v;
  endfunction

  function automatic logic m_valid(input logic [6:0] op, input logic [2:0] f3);
    if (op == LOAD_OP)  return (f3 != 3'd3) && (f3 != 3'd6) && (f3 != 3'd7);
    if (op == STORE_OP) return (f3 <= 3'd2);
    return 1'b0;
  endfunction

  task automatic run_op(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] rs2, input logic [31:0] rd, input int dly,
                        input string tag);
    logic        mem, trp;
    logic [31:0] exp_out;
    mem = m_valid(op, f3);
    trp = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
    trp = mem && (eff_off(f3, addr[1:0]) != int'(addr[1:0]));
`endif
    start = 1'b1; opcode = op; funct3 = f3; alu_out = addr; rs2_data = rs2;
    dc_rdata = $urandom;
    @(negedge clk);
    start = 1'b0; opcode = 7'($urandom); funct3 = 3'($urandom);
    alu_out = $urandom; rs2_data = $urandom;
    exp_out = '0;
    if (mem && !trp) begin
      check({tag, ".req"},   dc_req, 1'b1);
      check({tag, ".we"},    dc_we, (op == STORE_OP));
      check({tag, ".addr"},  dc_addr, addr & 32'hFFFF_FFFC);
      check({tag, ".be"},    dc_be, m_be(f3, addr[1:0]));
      if (op == STORE_OP) check({tag, ".wdata"}, dc_wdata, m_wdata(f3, rs2));
      check({tag, ".early_done"}, done, 1'b0);
      for (int i = 0; i < dly; i++) begin
        @(negedge clk);
        check({tag, ".req_hold"},  dc_req, 1'b1);
        check({tag, ".addr_hold"}, dc_addr, addr & 32'hFFFF_FFFC);
        check({tag, ".done_wait"}, done, 1'b0);
      end
      dc_ack = 1'b1; dc_rdata = rd;
      @(negedge clk);
      dc_ack = 1'b0; dc_rdata = $urandom;
      if (op == LOAD_OP) exp_out = m_load(f3, addr[1:0], rd);
    end
    check({tag, ".done"},   done, 1'b1);
    check({tag, ".noreq"},  dc_req, 1'b0);
    check({tag, ".result"}, dcache_out, exp_out);
`ifdef MEM_MISALIGN_TRAP_EN
    check({tag, ".misalign"}, misalign, trp);
`endif
    @(negedge clk);
    check({tag, ".done_off"}, done, 1'b0);
    check({tag, ".idle"},     busy, 1'b0);
    check({tag, ".hold"},     dcache_out, exp_out);
  endtask

  initial begin
    logic [6:0] rop;
    // reset for two cycles
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst.req",   dc_req, 1'b0);
    check("rst.we",    dc_we, 1'b0);
    check("rst.done",  done, 1'b0);
    check("rst.busy",  busy, 1'b0);
    check("rst.addr",  dc_addr, 32'd0);
    check("rst.wdata", dc_wdata, 32'd0);
    check("rst.be",    dc_be, 4'd0);
    check("rst.out",   dcache_out, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // ack while idle has no effect
    dc_ack = 1'b1;
    @(negedge clk);
    dc_ack = 1'b0;
    check("idle_ack.done", done, 1'b0);
    check("idle_ack.busy", busy, 1'b0);

    // LB 0x103, ack after 3 wait cycles
    run_op(LOAD_OP, 3'b000, 32'h0000_0103, 32'd0, 32'h80FF_7F01, 3, "lb");
    check("lb.const", dcache_out, 32'hFFFF_FF80);

    // LHU 0x202, ack in the first ACCESS cycle
    run_op(LOAD_OP, 3'b101, 32'h0000_0202, 32'd0, 32'hBEEF_1234, 0, "lhu");
    check("lhu.const", dcache_out, 32'h0000_BEEF);

    // SB 0x001, five no-ack cycles
    run_op(STORE_OP, 3'b000, 32'h0000_0001, 32'h1234_56AB, 32'hDEAD_BEEF, 5, "sb");

    // OP-IMM, then a start while busy
    start = 1'b1; opcode = OPIMM_OP; funct3 = 3'b000; alu_out = 32'h55;
    @(negedge clk);
    check("opimm.done", done, 1'b1);
    check("opimm.busy", busy, 1'b1);
    check("opimm.req",  dc_req, 1'b0);
    opcode = LOAD_OP; funct3 = 3'b010; alu_out = 32'h80;
    @(negedge clk);
    start = 1'b0;
    check("busy_start.done", done, 1'b0);
    check("busy_start.busy", busy, 1'b0);
    check("busy_start.req",  dc_req, 1'b0);
    @(negedge clk);
    check("busy_start.req2", dc_req, 1'b0);

    // LW misaligned: traps with the feature, reads word 0x004 without it
    run_op(LOAD_OP, 3'b010, 32'h0000_0006, 32'd0, 32'hCAFE_F00D, 1, "lw_mis");

    // invalid funct3 completes without an access
    run_op(LOAD_OP, 3'b011, 32'h0000_0010, 32'd0, 32'd0, 0, "ld_bad");
    run_op(STORE_OP, 3'b100, 32'h0000_0010, 32'h1, 32'd0, 0, "st_bad");

    // reset in the middle of ACCESS
    start = 1'b1; opcode = LOAD_OP; funct3 = 3'b010; alu_out = 32'h40;
    @(negedge clk);
    start = 1'b0;
    check("midrst.req_before", dc_req, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst.req",  dc_req, 1'b0);
    check("midrst.done", done, 1'b0);
    @(negedge clk);
    rst = 1'b0; dc_ack = 1'b1; dc_rdata = 32'h1111_2222;
    @(negedge clk);
    dc_ack = 1'b0;
    check("midrst.late_ack_done", done, 1'b0);
    check("midrst.busy", busy, 1'b0);
    check("midrst.out",  dcache_out, 32'd0);
    @(negedge clk);
    check("midrst.done2", done, 1'b0);

    // randomized mix
    for (int n = 0; n < 80; n++) begin
      case ($urandom_range(0, 4))
        0, 1:    rop = LOAD_OP;
        2, 3:    rop = STORE_OP;
        default: rop = OPIMM_OP;
      endcase
      run_op(rop, 3'($urandom), $urandom, $urandom, $urandom,
             int'($urandom_range(0, 3)), "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
